// File: rtl/ls_queue_pkg.sv
// Shared constants, entry layout and pointer helper for the load/store queue.
package ls_queue_pkg;

   localparam int ROB_WIDTH  = 4;
   localparam int DATA_WIDTH = 32;
   localparam int LSQ_SIZE   = 4;
   localparam int PTR_W      = $clog2(LSQ_SIZE);
   localparam int CNT_W      = $clog2(LSQ_SIZE + 1);

   localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   typedef enum logic {
      S_IDLE,
      S_WAIT_MEM
   } state_t;

   typedef struct packed {
      logic                  valid;
      logic                  is_store;
      logic [2:0]            funct3;
      logic [ROB_WIDTH-1:0]  rob_tag;
      logic [DATA_WIDTH-1:0] imm;
      logic                  base_ready;
      logic [DATA_WIDTH-1:0] base_value;
      logic [ROB_WIDTH-1:0]  base_tag;
      logic                  data_ready;
      logic [DATA_WIDTH-1:0] data_value;
      logic [ROB_WIDTH-1:0]  data_tag;
      logic                  announced;
      logic                  committed;
   } lsq_entry_t;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(LSQ_SIZE - 1)) ? '0 : p + PTR_W'(1);
   endfunction

endpackage

// File: rtl/ls_extend.sv
// Load-data size and sign/zero extension, purely combinational.
module ls_extend
   import ls_queue_pkg::*;
(
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] raw,
   output logic [DATA_WIDTH-1:0] result
);

   always_comb begin
      result = raw;
      if (funct3[1:0] == MEM_BYTE)
         result = funct3[2] ? {{(DATA_WIDTH-8){1'b0}}, raw[7:0]}
                            : {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      else if (funct3[1:0] == MEM_HALF)
         result = funct3[2] ? {{(DATA_WIDTH-16){1'b0}}, raw[15:0]}
                            : {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
   end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue: operand wakeup, store announce, commit-gated
// stores, head-only memory issue and misbranch recovery.
//   state      | meaning
//   S_IDLE     | no memory access outstanding; head may issue
//   S_WAIT_MEM | request driven, waiting for in_mem_done
module ls_queue
   import ls_queue_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  in_assign_valid,
   input  logic                  in_assign_is_store,
   input  logic [2:0]            in_assign_funct3,
   input  logic [ROB_WIDTH-1:0]  in_assign_rob_tag,
   input  logic [DATA_WIDTH-1:0] in_assign_imm,
   input  logic                  in_assign_base_ready,
   input  logic [DATA_WIDTH-1:0] in_assign_base_value,
   input  logic [ROB_WIDTH-1:0]  in_assign_base_tag,
   input  logic                  in_assign_data_ready,
   input  logic [DATA_WIDTH-1:0] in_assign_data_value,
   input  logic [ROB_WIDTH-1:0]  in_assign_data_tag,
   output logic                  out_full,
   input  logic [ROB_WIDTH-1:0]  in_cdb_rob_tag,
   input  logic [DATA_WIDTH-1:0] in_cdb_value,
   output logic [ROB_WIDTH-1:0]  out_ls_cdb_rob_tag,
   output logic [DATA_WIDTH-1:0] out_ls_cdb_value,
   input  logic                  in_commit_valid,
   input  logic [ROB_WIDTH-1:0]  in_committed_rob_tag,
   input  logic                  in_misbranch,
   output logic                  out_mem_req,
   output logic                  out_mem_we,
   output logic [DATA_WIDTH-1:0] out_mem_addr,
   output logic [DATA_WIDTH-1:0] out_mem_data,
   output logic [1:0]            out_mem_size,
   input  logic                  in_mem_done,
   input  logic [DATA_WIDTH-1:0] in_mem_data
);

   lsq_entry_t             q [LSQ_SIZE];
   logic [PTR_W-1:0]       head, tail;
   logic [CNT_W-1:0]       count;
   state_t                 state;
   logic                   inflight_load;
   logic                   inflight_drop;
   logic [ROB_WIDTH-1:0]   inflight_tag;
   logic [2:0]             inflight_funct3;
   logic [DATA_WIDTH-1:0]  ext_data;

   lsq_entry_t             head_e, new_e;
   logic                   issue_ok, done_now, deq, enq_ok, load_bcast;
   logic                   ann_found;
   logic [PTR_W-1:0]       ann_idx, keep_tail;
   logic [CNT_W-1:0]       keep_n;
   logic [LSQ_SIZE-1:0]    keep_mask;

   function automatic logic hit(input logic [ROB_WIDTH-1:0] want,
                                input logic [ROB_WIDTH-1:0] bus);
      return (bus != ZERO_ROB) && (bus == want);
   endfunction

   ls_extend u_extend (
      .funct3 (inflight_funct3),
      .raw    (in_mem_data),
      .result (ext_data)
   );

   assign out_full = (count == CNT_W'(LSQ_SIZE));
   assign head_e   = q[head];

   always_comb begin
      issue_ok   = (state == S_IDLE) && !in_misbranch && head_e.valid &&
                   (head_e.is_store ? (head_e.committed && head_e.base_ready && head_e.data_ready)
                                    : head_e.base_ready);
      done_now   = (state == S_WAIT_MEM) && in_mem_done;
      deq        = done_now && !inflight_drop;
      enq_ok     = in_assign_valid && !in_misbranch && (!out_full || deq);
      load_bcast = done_now && inflight_load && !inflight_drop && !in_misbranch;
   end

   // Oldest-first store announce search and the committed-store prefix kept on misbranch.
   always_comb begin
      logic [PTR_W-1:0] idx;
      logic             still;
      ann_found = 1'b0;
      ann_idx   = '0;
      keep_n    = '0;
      keep_tail = head;
      keep_mask = '0;
      still     = 1'b1;
      for (int i = 0; i < LSQ_SIZE; i++) begin
         idx = PTR_W'((int'(head) + i) % LSQ_SIZE);
         if (!ann_found && q[idx].valid && q[idx].is_store && q[idx].base_ready &&
             q[idx].data_ready && !q[idx].announced) begin
            ann_found = 1'b1;
            ann_idx   = idx;
         end
         if (still && q[idx].valid && q[idx].is_store && q[idx].committed) begin
            keep_n         = keep_n + CNT_W'(1);
            keep_mask[idx] = 1'b1;
            keep_tail      = next_ptr(keep_tail);
         end else begin
            still = 1'b0;
         end
      end
   end

   always_comb begin
      new_e            = '0;
      new_e.valid      = 1'b1;
      new_e.is_store   = in_assign_is_store;
      new_e.funct3     = in_assign_funct3;
      new_e.rob_tag    = in_assign_rob_tag;
      new_e.imm        = in_assign_imm;
      new_e.base_ready = in_assign_base_ready;
      new_e.base_value = in_assign_base_value;
      new_e.base_tag   = in_assign_base_tag;
      new_e.data_ready = in_assign_data_ready;
      new_e.data_value = in_assign_data_value;
      new_e.data_tag   = in_assign_data_tag;
      if (!in_assign_base_ready && hit(in_assign_base_tag, in_cdb_rob_tag)) begin
         new_e.base_ready = 1'b1;
         new_e.base_value = in_cdb_value;
      end else if (!in_assign_base_ready && hit(in_assign_base_tag, out_ls_cdb_rob_tag)) begin
         new_e.base_ready = 1'b1;
         new_e.base_value = out_ls_cdb_value;
      end
      if (!in_assign_data_ready && hit(in_assign_data_tag, in_cdb_rob_tag)) begin
         new_e.data_ready = 1'b1;
         new_e.data_value = in_cdb_value;
      end else if (!in_assign_data_ready && hit(in_assign_data_tag, out_ls_cdb_rob_tag)) begin
         new_e.data_ready = 1'b1;
         new_e.data_value = out_ls_cdb_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LSQ_SIZE; i++) q[i] <= '0;
         head               <= '0;
         tail               <= '0;
         count              <= '0;
         state              <= S_IDLE;
         inflight_load      <= 1'b0;
         inflight_drop      <= 1'b0;
         inflight_tag       <= ZERO_ROB;
         inflight_funct3    <= '0;
         out_ls_cdb_rob_tag <= ZERO_ROB;
         out_ls_cdb_value   <= '0;
         out_mem_req        <= 1'b0;
         out_mem_we         <= 1'b0;
         out_mem_addr       <= '0;
         out_mem_data       <= '0;
         out_mem_size       <= '0;
      end else if (ena) begin
         for (int i = 0; i < LSQ_SIZE; i++) begin
            if (q[i].valid && !q[i].base_ready) begin
               if (hit(q[i].base_tag, in_cdb_rob_tag)) begin
                  q[i].base_ready <= 1'b1;
                  q[i].base_value <= in_cdb_value;
               end else if (hit(q[i].base_tag, out_ls_cdb_rob_tag)) begin
                  q[i].base_ready <= 1'b1;
                  q[i].base_value <= out_ls_cdb_value;
               end
            end
            if (q[i].valid && !q[i].data_ready) begin
               if (hit(q[i].data_tag, in_cdb_rob_tag)) begin
                  q[i].data_ready <= 1'b1;
                  q[i].data_value <= in_cdb_value;
               end else if (hit(q[i].data_tag, out_ls_cdb_rob_tag)) begin
                  q[i].data_ready <= 1'b1;
                  q[i].data_value <= out_ls_cdb_value;
               end
            end
            if (in_commit_valid && q[i].valid && q[i].is_store &&
                q[i].rob_tag == in_committed_rob_tag)
               q[i].committed <= 1'b1;
         end

         // Load results win the broadcast slot; a ready store simply waits a cycle.
         out_ls_cdb_rob_tag <= ZERO_ROB;
         out_ls_cdb_value   <= '0;
         if (load_bcast) begin
            out_ls_cdb_rob_tag <= inflight_tag;
            out_ls_cdb_value   <= ext_data;
         end else if (ann_found && !in_misbranch) begin
            out_ls_cdb_rob_tag    <= q[ann_idx].rob_tag;
            q[ann_idx].announced  <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (issue_ok) begin
                  out_mem_req     <= 1'b1;
                  out_mem_we      <= head_e.is_store;
                  out_mem_addr    <= head_e.base_value + head_e.imm;
                  out_mem_data    <= head_e.data_value;
                  out_mem_size    <= head_e.funct3[1:0];
                  inflight_load   <= !head_e.is_store;
                  inflight_drop   <= 1'b0;
                  inflight_tag    <= head_e.rob_tag;
                  inflight_funct3 <= head_e.funct3;
                  state           <= S_WAIT_MEM;
               end
            end
            S_WAIT_MEM: begin
               if (in_mem_done) begin
                  out_mem_req <= 1'b0;
                  out_mem_we  <= 1'b0;
                  state       <= S_IDLE;
               end else if (in_misbranch && inflight_load) begin
                  inflight_drop <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (in_misbranch) begin
            // An in-flight load is not part of the kept prefix, so only a store pops here.
            for (int i = 0; i < LSQ_SIZE; i++)
               if (!keep_mask[i]) q[i].valid <= 1'b0;
            if (deq && !inflight_load) begin
               q[head].valid <= 1'b0;
               head          <= next_ptr(head);
               count         <= keep_n - CNT_W'(1);
            end else begin
               count <= keep_n;
            end
            tail <= keep_tail;
         end else begin
            if (deq) begin
               q[head].valid <= 1'b0;
               head          <= next_ptr(head);
            end
            if (enq_ok) begin
               q[tail] <= new_e;
               tail    <= next_ptr(tail);
            end
            count <= count + CNT_W'(enq_ok) - CNT_W'(deq);
         end
      end
   end

endmodule
